// File: rtl/counter_checker.sv
// counter_checker
//   Passive monitor for a WIDTH-bit up/down loadable counter. Runs a
//   cycle-accurate reference model from the same controls the counter sees
//   and compares it with the counter's output on every checking edge.
//
// Ports
//   clk        : clock, everything on posedge
//   rst        : synchronous active-high reset (shared with the counter)
//   en         : checking enable; the model tracks regardless
//   updown     : 1 = up, 0 = down
//   load, d    : parallel load (wins over updown) and its value
//   count      : counter output under test
//   mismatch   : one-cycle pulse after each failed compare
//   err_flag   : sticky "any mismatch since reset"
//   err_count  : saturating mismatch count
//   chk_count  : saturating number of compares performed
//   first_exp  : model value at the first mismatch
//   first_obs  : observed value at the first mismatch
//   halted     : checker stopped after an error (STOP_ON_ERR=1)
module counter_checker #(
    parameter int WIDTH       = 4,
    parameter int ERR_W       = 8,
    parameter int CHK_W       = 16,
    parameter int STOP_ON_ERR = 0,
    parameter int RESYNC      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             updown,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] count,
    output logic             mismatch,
    output logic             err_flag,
    output logic [ERR_W-1:0] err_count,
    output logic [CHK_W-1:0] chk_count,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_obs,
    output logic             halted
);

    typedef enum logic [1:0] {IDLE, CHECK, HALT} state_t;

    localparam logic [WIDTH-1:0] W_ONE = WIDTH'(1);
    localparam logic [ERR_W-1:0] E_ONE = ERR_W'(1);
    localparam logic [CHK_W-1:0] C_ONE = CHK_W'(1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] exp_q, exp_nxt, base;
    logic             fail, do_chk;

    always_comb begin
        do_chk    = (state == CHECK) && en;
        fail      = do_chk && (count != exp_q);
        // With resync the model continues from what the counter actually
        // shows, so one glitch yields one mismatch instead of a cascade.
        base      = ((RESYNC != 0) && fail) ? count : exp_q;
        exp_nxt   = load ? d : (updown ? base + W_ONE : base - W_ONE);
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = CHECK;
            CHECK:   if (fail && (STOP_ON_ERR != 0)) state_nxt = HALT;
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            exp_q     <= '0;
            mismatch  <= 1'b0;
            err_flag  <= 1'b0;
            err_count <= '0;
            chk_count <= '0;
            first_exp <= '0;
            first_obs <= '0;
        end else begin
            state    <= state_nxt;
            exp_q    <= exp_nxt;
            mismatch <= fail;
            if (do_chk && (chk_count != '1))
                chk_count <= chk_count + C_ONE;
            if (fail) begin
                err_flag <= 1'b1;
                if (err_count != '1)
                    err_count <= err_count + E_ONE;
                if (!err_flag) begin
                    first_exp <= exp_q;
                    first_obs <= count;
                end
            end
        end
    end

    assign halted = (state == HALT);

endmodule

// File: tb/tb_counter_checker.sv
module tb_counter_checker;

    logic       clk = 1'b0;
    logic       rst, en, updown, load;
    logic [3:0] d, ctr;
    wire  [3:0] count = ctr;

    always #5 clk = ~clk;

    // default instance: RESYNC=1, no stop
    logic a_mi, a_ef, a_h; logic [7:0] a_ec; logic [15:0] a_cc; logic [3:0] a_fe, a_fo;
    // stop-on-error instance
    logic b_mi, b_ef, b_h; logic [7:0] b_ec; logic [15:0] b_cc; logic [3:0] b_fe, b_fo;
    // narrow error counter, no resync
    logic c_mi, c_ef, c_h; logic [1:0] c_ec; logic [15:0] c_cc; logic [3:0] c_fe, c_fo;

    counter_checker u_dut (.clk(clk), .rst(rst), .en(en), .updown(updown), .load(load),
        .d(d), .count(count), .mismatch(a_mi), .err_flag(a_ef), .err_count(a_ec),
        .chk_count(a_cc), .first_exp(a_fe), .first_obs(a_fo), .halted(a_h));

    counter_checker #(.STOP_ON_ERR(1)) u_stop (.clk(clk), .rst(rst), .en(en), .updown(updown),
        .load(load), .d(d), .count(count), .mismatch(b_mi), .err_flag(b_ef), .err_count(b_ec),
        .chk_count(b_cc), .first_exp(b_fe), .first_obs(b_fo), .halted(b_h));

    counter_checker #(.ERR_W(2), .RESYNC(0)) u_sat (.clk(clk), .rst(rst), .en(en), .updown(updown),
        .load(load), .d(d), .count(count), .mismatch(c_mi), .err_flag(c_ef), .err_count(c_ec),
        .chk_count(c_cc), .first_exp(c_fe), .first_obs(c_fo), .halted(c_h));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: phase 0 = waiting after reset, 1 = checking, 2 = halted.
    typedef struct {
        int exp, st, mism, eflag, ecnt, ccnt, fexp, fobs;
    } m_t;

    m_t ma, mb, mc;

    function automatic m_t mstep(input m_t m, input bit stop, input bit rs, input int emax,
                                 input int cmax, input bit r, input bit e, input bit u,
                                 input bit l, input int dv, input int cnt);
        m_t n;
        bit compare, bad;
        int base;
        n = m;
        if (r) begin
            n.exp = 0; n.st = 0; n.mism = 0; n.eflag = 0;
            n.ecnt = 0; n.ccnt = 0; n.fexp = 0; n.fobs = 0;
            return n;
        end
        compare = (m.st == 1) && e;
        bad     = compare && (cnt != m.exp);
        base    = (rs && bad) ? cnt : m.exp;
        n.exp   = l ? dv : (u ? (base + 1) % 16 : (base + 15) % 16);
        n.mism  = bad;
        if (m.st == 0) n.st = 1;
        else if (bad && stop) n.st = 2;
        if (compare) n.ccnt = (m.ccnt + 1 > cmax) ? cmax : m.ccnt + 1;
        if (bad) begin
            n.eflag = 1;
            n.ecnt  = (m.ecnt + 1 > emax) ? emax : m.ecnt + 1;
            if (m.eflag == 0) begin
                n.fexp = m.exp;
                n.fobs = cnt;
            end
        end
        return n;
    endfunction

    task automatic cmp(input string p, input m_t m, input logic mi, input logic ef, input int ec,
                       input int cc, input logic [3:0] fe, input logic [3:0] fo, input logic h);
        chk({p, ".mismatch"},  int'(mi), m.mism);
        chk({p, ".err_flag"},  int'(ef), m.eflag);
        chk({p, ".err_count"}, ec, m.ecnt);
        chk({p, ".chk_count"}, cc, m.ccnt);
        chk({p, ".first_exp"}, int'(fe), m.fexp);
        chk({p, ".first_obs"}, int'(fo), m.fobs);
        chk({p, ".halted"},    int'(h), (m.st == 2) ? 1 : 0);
    endtask

    bit stuck = 0;

    // One clock: models and the emulated counter see the pre-edge inputs;
    // outputs are checked on the following falling edge.
    task automatic step();
        int cn;
        @(posedge clk);
        ma = mstep(ma, 0, 1, 255, 65535, rst, en, updown, load, int'(d), int'(count));
        mb = mstep(mb, 1, 1, 255, 65535, rst, en, updown, load, int'(d), int'(count));
        mc = mstep(mc, 0, 0, 3,   65535, rst, en, updown, load, int'(d), int'(count));
        if (rst) cn = 0;
        else if (load) cn = int'(d);
        else cn = updown ? (int'(count) + 1) % 16 : (int'(count) + 15) % 16;
        @(negedge clk);
        ctr = stuck ? 4'd0 : 4'(cn);
        cmp("dut",  ma, a_mi, a_ef, int'(a_ec), int'(a_cc), a_fe, a_fo, a_h);
        cmp("stop", mb, b_mi, b_ef, int'(b_ec), int'(b_cc), b_fe, b_fo, b_h);
        cmp("sat",  mc, c_mi, c_ef, int'(c_ec), int'(c_cc), c_fe, c_fo, c_h);
    endtask

    initial begin
        rst = 1; en = 1; updown = 1; load = 0; d = 0; ctr = 0;
        ma = mstep(ma, 0, 1, 255, 65535, 1, 0, 0, 0, 0, 0);
        mb = ma; mc = ma;

        // reset, then 20 clean up-counts through the 15->0 wrap
        repeat (2) step();
        rst = 0;
        repeat (20) step();
        chk("plan_chk19", int'(a_cc), 19);
        chk("plan_noerr", int'(a_ef), 0);

        // load beats updown, then count down through 0->15
        load = 1; d = 3; updown = 1; step();
        load = 0; updown = 0;
        repeat (5) step();
        chk("plan_down_ctr", int'(count), 14);
        chk("plan_down_err", int'(a_ec), 0);

        // single glitch 5 -> 9
        load = 1; d = 4; step();
        load = 0; updown = 1; step();
        ctr = 4'd9;
        step();
        chk("fault_pulse", int'(a_mi), 1);
        chk("fault_ecnt",  int'(a_ec), 1);
        chk("fault_fexp",  int'(a_fe), 5);
        chk("fault_fobs",  int'(a_fo), 9);
        chk("stop_halt",   int'(b_h), 1);
        repeat (3) step();
        chk("resync_ecnt", int'(a_ec), 1);
        chk("resync_pulse", int'(a_mi), 0);
        repeat (2) begin ctr = ctr + 4'd7; step(); end
        chk("stop_ecnt_frozen", int'(b_ec), 1);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            rst    = ($urandom_range(39) == 0);
            en     = ($urandom_range(3) != 0);
            load   = ($urandom_range(5) == 0);
            updown = 1'($urandom);
            d      = 4'($urandom);
            if ($urandom_range(9) == 0) ctr = 4'($urandom);
            step();
        end

        // stuck-at-0 counter while counting up
        rst = 1; en = 1; load = 0; updown = 1; step();
        rst = 0; stuck = 1;
        repeat (8) step();
        chk("sat_ecnt", int'(c_ec), 3);
        chk("sat_flag", int'(c_ef), 1);
        chk("sat_fexp", int'(c_fe), 1);
        chk("sat_fobs", int'(c_fo), 0);

        // reset in the middle of an error run
        rst = 1; step();
        chk("midrst_ecnt", int'(c_ec), 0);
        chk("midrst_flag", int'(a_ef), 0);
        rst = 0; stuck = 0;

        // faults with checking disabled
        repeat (3) step();
        en = 0;
        for (int i = 0; i < 4; i++) begin
            ctr = ctr + 4'd5;
            step();
            chk("en_off_pulse", int'(a_mi), 0);
        end
        chk("en_off_chk", int'(a_cc), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_checker.md
# counter_checker

Synthesizable self-checking monitor for the 4-bit up/down loadable counter. Sits on the monitor side of the counter interface, passively samples the same controls the driver applies (updown, load, d) plus the DUT's count, and runs a cycle-accurate reference model. Every clock it compares observed against expected count, and reports mismatches, error statistics and first-failure capture to the testbench or a status register block.

## Interface
Parameters:
- WIDTH, 4: width of d, count and model.
- ERR_W, 8: width of the saturating error counter.
- CHK_W, 16: width of the saturating comparisons-performed counter.
- STOP_ON_ERR, 0: 1 = enter HALT on the first mismatch and stop checking.
- RESYNC, 1: 1 = after a mismatch, the model continues from the observed count.

Ports:
- clk, in, 1: single clock, all logic on posedge.
- rst, in, 1: synchronous, active-high reset. Same reset the counter DUT sees.
- en, in, 1: checking enable. The model always tracks; compares only when en=1.
- updown, in, 1: 1 = count up, 0 = count down.
- load, in, 1: parallel load, priority over updown.
- d, in, WIDTH: load value.
- count, in, WIDTH: DUT output.
- mismatch, out, 1: one-cycle pulse per failed compare.
- err_flag, out, 1: sticky; set on any mismatch, cleared only by rst.
- err_count, out, ERR_W: saturating mismatch count.
- chk_count, out, CHK_W: saturating number of compares performed.
- first_exp, out, WIDTH: expected value at the first mismatch.
- first_obs, out, WIDTH: observed value at the first mismatch.
- halted, out, 1: high in HALT.

## Operation
- Reference model register exp, updated every edge:
  - rst: 0
  - else load: d
  - else updown: base+1
  - else: base-1
  - Arithmetic is modulo 2^WIDTH, so 15+1=0 and 0-1=15.
  - base = count when RESYNC=1 and this edge is a mismatch; otherwise base = exp.
- Compare at each edge: fail = (state==CHECK) && en && (count != exp). Uses values sampled just before the edge.
- FSM states: IDLE, CHECK, HALT.
  - Any state with rst goes to IDLE.
  - IDLE goes to CHECK on the first edge with rst=0. No compare is made in IDLE.
  - CHECK goes to HALT on fail when STOP_ON_ERR=1; otherwise it stays in CHECK.
  - HALT is held until rst. In HALT: no compares, counters frozen, exp keeps tracking.
- On fail:
  - mismatch is 1 for the following cycle.
  - err_flag is set.
  - err_count is incremented, saturating at all-ones.
  - If err_flag was 0, capture first_exp=exp and first_obs=count.
- chk_count increments, saturating, on every edge where state==CHECK and en=1.
- Simultaneous load and updown: load wins.
- Controls during rst are ignored. exp is 0 after the reset edge, matching the DUT.

## Timing
- Reset values: all outputs 0, state IDLE, exp 0.
- Compare latency: the DUT value that settles after edge N is compared at edge N+1. mismatch, err_flag and first_* are visible after edge N+1 (registered, 1 cycle).
- rst deasserted before edge R: edge R is IDLE→CHECK with no compare. The first compare is at edge R+1.
- rst asserted mid-operation: reset takes effect at that edge. Outputs clear the following cycle, and no compare is made on that edge.
- en toggling: takes effect the same edge it is sampled. exp is unaffected by en.

## Test plan
- Reset then up-count: rst 2 cycles, then updown=1, load=0, en=1 for 20 cycles with a correct DUT → err_flag=0, chk_count=19, through 15→0 wrap.
- Load/down priority: load=1, d=3, updown=1, then load=0, updown=0 for 5 cycles → exp follows 3,2,1,0,15,14; no mismatch.
- Injected fault: force count to 9 when 5 is expected, once, RESYNC=1 → a single mismatch pulse, err_count=1, first_exp=5, first_obs=9, and later compares pass from 10 onward.
- Stop on error: STOP_ON_ERR=1, inject the same fault → halted=1 the next cycle, err_count stays 1, and chk_count frozen despite further faults.
- Saturation: ERR_W=2, continuous stuck-at-0 DUT while counting up, RESYNC=0 → err_count saturates at 3, err_flag=1, and first_* report the first failure only.
- Mid-run reset and en gating: rst pulse during an error run → all outputs 0 next cycle; en=0 while faults are injected → no mismatch and chk_count unchanged.
